// File: rtl/pipe_adder_pkg.sv
// Shared constants and parameter helpers for the pipelined adder.
// Optional flag outputs are enabled by defining PIPE_ADDER_FLAGS_EN (default: off).
package pipe_adder_pkg;

  localparam int DEFAULT_DATA_LEN  = 32;
  localparam int DEFAULT_STAGE_NUM = 4;

  function automatic bit paramsLegal(input int dataLen, input int stageNum);
    return (stageNum >= 1) && ((dataLen % stageNum) == 0);
  endfunction

  // Falls back to the full width when the depth is illegal so elaboration reaches the check.
  function automatic int chunkWidth(input int dataLen, input int stageNum);
    return (stageNum >= 1) ? (dataLen / stageNum) : dataLen;
  endfunction

endpackage

// File: rtl/pipe_adder_stage.sv
// One pipeline stage: ripple-adds a single cw-bit chunk and registers carry, sum-so-far and operands.
// With PIPE_ADDER_FLAGS_EN defined the last stage also registers signed overflow and zero.
module pipe_adder_stage
  import pipe_adder_pkg::*;
#(
  parameter int cw        = 8,
  parameter int data_len  = 32,
  parameter int stage_idx = 0,
  parameter int is_last   = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_en,
  input  logic                i_valid,
  input  logic                i_carry,
  input  logic [data_len-1:0] i_a,
  input  logic [data_len-1:0] i_b,
  input  logic [data_len-1:0] i_s,
`ifdef PIPE_ADDER_FLAGS_EN
  output logic                o_ovf,
  output logic                o_zero,
`endif
  output logic                o_valid,
  output logic                o_carry,
  output logic [data_len-1:0] o_a,
  output logic [data_len-1:0] o_b,
  output logic [data_len-1:0] o_s
);

  localparam int LO = stage_idx * cw;

  logic [cw:0]         w_chunkSum;
  logic [data_len-1:0] w_sNext;
  logic                r_valid;
  logic                r_carry;
  logic [data_len-1:0] r_a;
  logic [data_len-1:0] r_b;
  logic [data_len-1:0] r_s;

  always_comb begin
    w_chunkSum = {1'b0, i_a[LO +: cw]} + {1'b0, i_b[LO +: cw]} + {{cw{1'b0}}, i_carry};
    w_sNext = i_s;
    w_sNext[LO +: cw] = w_chunkSum[cw-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_carry <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_s     <= '0;
    end else if (i_en) begin
      r_valid <= i_valid;
      r_carry <= w_chunkSum[cw];
      r_a     <= i_a;
      r_b     <= i_b;
      r_s     <= w_sNext;
    end
  end

  assign o_valid = r_valid;
  assign o_carry = r_carry;
  assign o_a     = r_a;
  assign o_b     = r_b;
  assign o_s     = r_s;

`ifdef PIPE_ADDER_FLAGS_EN
  // Only the final stage sees the complete sum, so only it owns the flag registers.
  if (is_last != 0) begin : g_flags
    logic w_ovf;
    logic w_zero;
    logic r_ovf;
    logic r_zero;

    assign w_ovf  = (i_a[data_len-1] == i_b[data_len-1]) && (w_sNext[data_len-1] != i_a[data_len-1]);
    assign w_zero = ~|w_sNext;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_ovf  <= 1'b0;
        r_zero <= 1'b0;
      end else if (i_en) begin
        r_ovf  <= w_ovf;
        r_zero <= w_zero;
      end
    end

    assign o_ovf  = r_ovf;
    assign o_zero = r_zero;
  end else begin : g_noFlags
    assign o_ovf  = 1'b0;
    assign o_zero = 1'b0;
  end
`endif

endmodule

// File: rtl/pipe_adder.sv
// Pipelined add/subtract unit: stage_num chunk stages with a single global advance (valid/ready both sides).
// Define PIPE_ADDER_FLAGS_EN to add the registered ovf and zero outputs.
module pipe_adder
  import pipe_adder_pkg::*;
#(
  parameter int data_len  = DEFAULT_DATA_LEN,
  parameter int stage_num = DEFAULT_STAGE_NUM
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [data_len-1:0] a,
  input  logic [data_len-1:0] b,
  input  logic                cin,
  input  logic                sub,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [data_len-1:0] s,
`ifdef PIPE_ADDER_FLAGS_EN
  output logic                ovf,
  output logic                zero,
`endif
  output logic                cout
);

  localparam int cw = chunkWidth(data_len, stage_num);

  if (!paramsLegal(data_len, stage_num)) begin : g_badParams
    $error("pipe_adder: data_len must be a multiple of stage_num, and stage_num must be >= 1");
  end

  logic                w_adv;
  logic                w_valid [0:stage_num];
  logic                w_carry [0:stage_num];
  logic [data_len-1:0] w_a     [0:stage_num];
  logic [data_len-1:0] w_b     [0:stage_num];
  logic [data_len-1:0] w_s     [0:stage_num];
`ifdef PIPE_ADDER_FLAGS_EN
  logic                w_ovf   [0:stage_num-1];
  logic                w_zero  [0:stage_num-1];
`endif

  // The whole pipe moves in lockstep; a stalled result freezes every stage behind it.
  assign w_adv    = !out_valid || out_ready;
  assign in_ready = w_adv;

  assign w_valid[0] = in_valid;
  assign w_carry[0] = sub | cin;
  assign w_a[0]     = a;
  assign w_b[0]     = sub ? ~b : b;
  assign w_s[0]     = '0;

  for (genvar k = 0; k < stage_num; k++) begin : g_stage
    pipe_adder_stage #(
      .cw        (cw),
      .data_len  (data_len),
      .stage_idx (k),
      .is_last   ((k == stage_num - 1) ? 1 : 0)
    ) u_stage (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_en    (w_adv),
      .i_valid (w_valid[k]),
      .i_carry (w_carry[k]),
      .i_a     (w_a[k]),
      .i_b     (w_b[k]),
      .i_s     (w_s[k]),
`ifdef PIPE_ADDER_FLAGS_EN
      .o_ovf   (w_ovf[k]),
      .o_zero  (w_zero[k]),
`endif
      .o_valid (w_valid[k+1]),
      .o_carry (w_carry[k+1]),
      .o_a     (w_a[k+1]),
      .o_b     (w_b[k+1]),
      .o_s     (w_s[k+1])
    );
  end

  assign out_valid = w_valid[stage_num];
  assign s         = w_s[stage_num];
  assign cout      = w_carry[stage_num];
`ifdef PIPE_ADDER_FLAGS_EN
  assign ovf       = w_ovf[stage_num-1];
  assign zero      = w_zero[stage_num-1];
`endif

endmodule

// File: tb/tb_pipe_adder.sv
// Self-checking bench for pipe_adder: directed cases on an 8-bit/2-stage unit plus random traffic on 8-bit/8-stage.
// Flag outputs are connected and checked only when PIPE_ADDER_FLAGS_EN is defined.
module tb_pipe_adder;

  localparam int SN  = 2;
  localparam int SN8 = 8;

  typedef struct {
    logic [7:0] s;
    logic       cout;
    logic       ovf;
    logic       zero;
    int         adv;
  } expTxn;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       inValid, inReady, cin, sub, outValid, outReady, cout, ovf, zero;
  logic [7:0] a, b, s;
  logic       inValid8, inReady8, cin8, sub8, outValid8, outReady8, cout8, ovf8, zero8;
  logic [7:0] a8, b8, s8;

  int    numChecks = 0;
  int    numFails  = 0;
  int    advCount  = 0;
  int    advCount8 = 0;
  int    popCount  = 0;
  int    popCount8 = 0;
  int    pushCount8 = 0;
  bit    randomDone = 1'b0;
  expTxn expQ[$];
  expTxn expQ8[$];

  always #5 clk = ~clk;

  pipe_adder #(.data_len(8), .stage_num(SN)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (inValid),
    .in_ready  (inReady),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (outValid),
    .out_ready (outReady),
    .s         (s),
`ifdef PIPE_ADDER_FLAGS_EN
    .ovf       (ovf),
    .zero      (zero),
`endif
    .cout      (cout)
  );

  pipe_adder #(.data_len(8), .stage_num(SN8)) u_dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (inValid8),
    .in_ready  (inReady8),
    .a         (a8),
    .b         (b8),
    .cin       (cin8),
    .sub       (sub8),
    .out_valid (outValid8),
    .out_ready (outReady8),
    .s         (s8),
`ifdef PIPE_ADDER_FLAGS_EN
    .ovf       (ovf8),
    .zero      (zero8),
`endif
    .cout      (cout8)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    numChecks++;
    if (actual !== expected) begin
      numFails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  function automatic expTxn modelOp(input logic [7:0] ia, input logic [7:0] ib, input logic ic, input logic is);
    expTxn      r;
    logic [7:0] bEff;
    logic [8:0] full;
    bEff   = is ? ~ib : ib;
    full   = {1'b0, ia} + {1'b0, bEff} + {8'd0, (is | ic)};
    r.s    = full[7:0];
    r.cout = full[8];
    r.ovf  = (ia[7] == bEff[7]) && (full[7] != ia[7]);
    r.zero = (full[7:0] == 8'd0);
    r.adv  = 0;
    return r;
  endfunction

  // Record accepted beats and count pipeline advances as seen at each rising edge.
  always @(posedge clk) begin : sbPush
    expTxn t;
    if (rst_n) begin
      if (inValid && inReady) begin
        t = modelOp(a, b, cin, sub);
        t.adv = advCount;
        expQ.push_back(t);
      end
      if (!outValid || outReady) advCount++;
      if (inValid8 && inReady8) begin
        t = modelOp(a8, b8, cin8, sub8);
        t.adv = advCount8;
        expQ8.push_back(t);
        pushCount8++;
      end
      if (!outValid8 || outReady8) advCount8++;
    end
  end

  always @(negedge rst_n) begin
    expQ.delete();
    expQ8.delete();
  end

  always @(negedge clk) begin : sbCheck
    expTxn e;
    if (rst_n && outValid) begin
      if (expQ.size() == 0) begin
        checkOutput("spuriousValid", 1, 0);
      end else begin
        e = expQ[0];
        checkOutput("latency", advCount - e.adv, SN);
        checkOutput("sum", s, e.s);
        checkOutput("cout", cout, e.cout);
`ifdef PIPE_ADDER_FLAGS_EN
        checkOutput("ovf", ovf, e.ovf);
        checkOutput("zero", zero, e.zero);
`endif
        if (outReady) begin
          void'(expQ.pop_front());
          popCount++;
        end
      end
    end
    if (rst_n && outValid8) begin
      if (expQ8.size() == 0) begin
        checkOutput("spuriousValid8", 1, 0);
      end else begin
        e = expQ8[0];
        checkOutput("latency8", advCount8 - e.adv, SN8);
        checkOutput("sum8", s8, e.s);
        checkOutput("cout8", cout8, e.cout);
`ifdef PIPE_ADDER_FLAGS_EN
        checkOutput("ovf8", ovf8, e.ovf);
        checkOutput("zero8", zero8, e.zero);
`endif
        if (outReady8) begin
          void'(expQ8.pop_front());
          popCount8++;
        end
      end
    end
  end

  // Presents one beat and returns at posedge+1 after it is accepted; inValid is left high.
  task automatic applyStimulus(input logic [7:0] ia, input logic [7:0] ib, input logic ic, input logic is);
    bit accepted = 1'b0;
    inValid = 1'b1;
    a = ia;
    b = ib;
    cin = ic;
    sub = is;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      accepted = inReady;
      @(posedge clk);
      #1;
      if (accepted) break;
    end
    if (!accepted) checkOutput("acceptTimeout", 0, 1);
  endtask

  // Waits for the single in-flight result and compares it against fixed values.
  task automatic expectResult(input string tag, input logic [7:0] es, input logic ec, input logic eo, input logic ez);
    int waited = 0;
    for (int t = 1; t <= 20; t++) begin
      @(negedge clk);
      if (outValid) begin
        waited = t;
        break;
      end
    end
    checkOutput({tag, "_latency"}, waited, SN);
    checkOutput({tag, "_s"}, s, es);
    checkOutput({tag, "_cout"}, cout, ec);
`ifdef PIPE_ADDER_FLAGS_EN
    checkOutput({tag, "_ovf"}, ovf, eo);
    checkOutput({tag, "_zero"}, zero, ez);
`endif
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] heldS;
    int         popStart;
    bit         acc8;

    rst_n = 1'b0;
    inValid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; outReady = 1'b0;
    inValid8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0; sub8 = 1'b0; outReady8 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rstOutValid", outValid, 0);
    checkOutput("rstSum", s, 8'h00);
    checkOutput("rstCout", cout, 0);
    checkOutput("rstInReady", inReady, 1);
    outReady = 1'b1;
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;

    applyStimulus(8'hFF, 8'h01, 1'b0, 1'b0);
    inValid = 1'b0;
    checkOutput("t1_notYet", outValid, 0);
    expectResult("t1", 8'h00, 1'b1, 1'b0, 1'b1);
    applyStimulus(8'h05, 8'h07, 1'b0, 1'b1);
    inValid = 1'b0;
    expectResult("t2", 8'hFE, 1'b0, 1'b0, 1'b0);
    applyStimulus(8'h7F, 8'h01, 1'b0, 1'b0);
    inValid = 1'b0;
    expectResult("t3a", 8'h80, 1'b0, 1'b1, 1'b0);
    applyStimulus(8'h80, 8'h01, 1'b0, 1'b1);
    inValid = 1'b0;
    expectResult("t3b", 8'h7F, 1'b1, 1'b1, 1'b0);
    applyStimulus(8'h10, 8'h20, 1'b1, 1'b0);
    inValid = 1'b0;
    expectResult("cinAdd", 8'h31, 1'b0, 1'b0, 1'b0);
    applyStimulus(8'h05, 8'h07, 1'b1, 1'b1);
    inValid = 1'b0;
    expectResult("subIgnoresCin", 8'hFE, 1'b0, 1'b0, 1'b0);

    popStart = popCount;
    fork
      begin
        for (int i = 0; i < 6; i++) applyStimulus(8'(i * 37 + 3), 8'(i * 11 + 200), i[0], i[1]);
        inValid = 1'b0;
      end
      begin
        repeat (4) @(posedge clk);
        #1 outReady = 1'b0;
        checkOutput("t4_stallValid", outValid, 1);
        heldS = s;
        repeat (3) begin
          @(negedge clk);
          checkOutput("t4_inReady", inReady, 0);
          checkOutput("t4_hold", s, heldS);
        end
        @(posedge clk);
        #1 outReady = 1'b1;
      end
    join
    for (int t = 0; t < 50 && expQ.size() != 0; t++) @(negedge clk);
    checkOutput("t4_count", popCount - popStart, 6);
    checkOutput("t4_drain", expQ.size(), 0);
    @(posedge clk);
    #1;

    applyStimulus(8'h11, 8'h22, 1'b0, 1'b0);
    applyStimulus(8'h33, 8'h44, 1'b0, 1'b0);
    inValid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checkOutput("t5_asyncValid", outValid, 0);
    checkOutput("t5_asyncSum", s, 8'h00);
    checkOutput("t5_asyncCout", cout, 0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      checkOutput("t5_noStale", outValid, 0);
    end
    @(posedge clk);
    #1;
    applyStimulus(8'h40, 8'h02, 1'b1, 1'b0);
    inValid = 1'b0;
    expectResult("t5_after", 8'h43, 1'b0, 1'b0, 1'b0);

    fork
      begin
        for (int i = 0; i < 300; i++) begin
          if ($urandom_range(3) == 0) begin
            inValid = 1'b0;
            @(posedge clk);
            #1;
          end
          applyStimulus(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
        end
        inValid = 1'b0;
        randomDone = 1'b1;
      end
      begin
        while (!randomDone) begin
          @(posedge clk);
          #1 outReady = ($urandom_range(2) != 0);
        end
        outReady = 1'b1;
      end
      begin
        for (int cyc = 0; cyc < 2000; cyc++) begin
          @(negedge clk);
          acc8 = inValid8 && inReady8;
          @(posedge clk);
          #1;
          if (!inValid8 || acc8) begin
            inValid8 = ($urandom_range(3) != 0);
            a8 = 8'($urandom);
            b8 = 8'($urandom);
            cin8 = 1'($urandom);
            sub8 = 1'($urandom);
          end
          outReady8 = ($urandom_range(2) != 0);
        end
        inValid8 = 1'b0;
        outReady8 = 1'b1;
      end
    join

    for (int t = 0; t < 100 && (expQ.size() != 0 || expQ8.size() != 0); t++) @(negedge clk);
    checkOutput("drainMain", expQ.size(), 0);
    checkOutput("drain8", expQ8.size(), 0);
    checkOutput("count8", popCount8, pushCount8);

    $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
    $finish;
  end

endmodule
